requant_pool: RTL and testbench
===============================

# requant_pool

Downstream stage of the convolution / partial-sum path. Consumes the 24-bit signed accumulated partial sums of one output channel in raster order and applies bias, rounding right-shift, optional ReLU and saturation to 8 bits. It then optionally performs 2x2 stride-2 max pooling. The 8-bit results are emitted as an addressed stream with valid/ready handshake into the next layer's input image buffer.

## Interface
- MAX_H, 16, maximum input rows
- MAX_W, 15, maximum input columns
- ACC_WIDTH, 24, partial-sum width (signed)
- DATA_WIDTH, 8, output pixel width
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; samples configuration, begins a frame; ignored unless IDLE
- in_w  in  5  input columns (2..MAX_W), sampled on start
- in_h  in  5  input rows (2..MAX_H), sampled on start
- bias  in  ACC_WIDTH  signed bias, sampled on start
- shift  in  5  arithmetic right-shift amount 0..23, sampled on start
- en_relu  in  1  1: ReLU, output unsigned 0..255; 0: signed int8 -128..127; sampled on start
- pool_en  in  1  1: 2x2 max pool; 0: pass-through; sampled on start
- in_valid  in  1  partial sum present
- in_data  in  ACC_WIDTH  signed partial sum
- in_ready  out  1  block accepts in_data this cycle
- out_valid  out  1  out_pixel/out_addr valid
- out_pixel  out  DATA_WIDTH  result pixel
- out_addr  out  8  raster index of result in output image
- out_ready  in  1  consumer accepts output
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last output handshake

## Operation
- States: IDLE -> RUN on start; RUN -> DRAIN when the last input (row in_h-1, col in_w-1) is accepted; DRAIN -> DONE when the pipeline is empty and no output is pending; DONE -> IDLE after one cycle (done=1).
- Requant per input: t = in_data + bias, computed at 25 bits. If shift>0, add 1<<(shift-1), then apply arithmetic >>> shift. With en_relu, clamp to [0,255]; otherwise clamp to [-128,127] and emit two's complement. Keep the clamped value as 9-bit signed q for comparisons.
- Counters row/col follow input acceptance. col wraps at in_w-1; row increments on wrap.
- Pass-through (pool_en=0): every q is emitted with out_addr = row*in_w + col.
- Pool (pool_en=1), for input (r,c):
  - Even r, even c: h=q.
  - Even r, odd c: rowbuf[c>>1] = max(h,q).
  - Odd r, even c: h=q.
  - Odd r, odd c: emit max(rowbuf[c>>1], h, q) with out_addr = (r>>1)*(in_w>>1) + (c>>1).
  - Odd in_w: the last column is consumed and discarded. Odd in_h: the last row is consumed and discarded.
  - rowbuf is MAX_W/2 entries of 9 bits and needs no clearing.
- Comparisons are signed on q, so results are correct in both modes.

## Timing
- Reset: state=IDLE; in_ready=0, out_valid=0, out_pixel=0, out_addr=0, busy=0, done=0; counters and config registers 0.
- in_ready = (state==RUN) && !(out_valid && !out_ready). Accept = in_valid && in_ready.
- Pipeline: S1 registers q and (r,c) one cycle after accept. S2 registers out_pixel/out_addr/out_valid one cycle after S1.
- Output latency is 2 cycles from accepting the completing input to out_valid.
- Stall: while out_valid && !out_ready, S1 and S2 hold and out_pixel/out_addr stay stable. out_valid clears on handshake unless S1 presents a new result in the same cycle.
- Full throughput: one input per cycle with out_ready held high.
- done: asserted the cycle after the final output handshake. In pool mode with odd dimensions, a discarded tail gives the final output earlier than the final input, so done follows both the last accept and the last handshake. busy falls together with done.
- start during RUN/DRAIN/DONE is ignored. start and in_valid in the same IDLE cycle: the input is not accepted (in_ready=0 in IDLE).
- Reset mid-frame clears immediately; any partial frame is lost and no done is emitted.

## Structure
- Shared package npu_pkg: ACC_WIDTH, DATA_WIDTH, state enum {IDLE,RUN,DRAIN,DONE}.
- Sub-module requant_unit: combinational bias, round, shift and clamp, producing 9-bit q and DATA_WIDTH out. Instantiated once and reusable by other layers.

## Test plan
- Pass-through, bias=0, shift=0, en_relu=1: inputs -5, 7, 300 -> outputs 0, 7, 255 at addr 0, 1, 2, each 2 cycles after accept.
- Rounding, shift=2, bias=1, en_relu=0: inputs 5, -7, 1000 -> outputs 2 ((6+2)>>2), -1, 127.
- Pool 4x4, en_relu=1, inputs = index 0..15 -> 4 outputs 5, 7, 13, 15 at addr 0..3; done 1 cycle after last handshake.
- Pool 13x14 (in_w=13, in_h=14): 182 inputs -> exactly 42 outputs, addr 0..41. Column 12 is never represented in any output.
- Backpressure: out_ready low for 5 cycles during a stream -> in_ready low, outputs held stable, no loss or duplication against the reference model.
- Reset asserted mid-frame -> all outputs 0 immediately. A fresh start then produces a correct full frame.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared definitions for the NPU datapath stages: widths, limits, control
// states and small helpers on the 9-bit requantised value.
package npu_pkg;

    localparam int ACC_WIDTH  = 24;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_H      = 16;
    localparam int MAX_W      = 15;
    localparam int ADDR_WIDTH = 8;
    localparam int Q_WIDTH    = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Signed maximum of two requantised values.
    function automatic logic signed [Q_WIDTH-1:0] max9(
        input logic signed [Q_WIDTH-1:0] a,
        input logic signed [Q_WIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // 9-bit q to output pixel: unsigned 0..255 under ReLU, otherwise int8
    // whose sign bit is the sign of q (q is already clamped to -128..127).
    function automatic logic [DATA_WIDTH-1:0] to_pix(
        input logic signed [Q_WIDTH-1:0] q,
        input logic                      relu
    );
        return relu ? q[7:0] : {q[8], q[6:0]};
    endfunction

endpackage

// File: rtl/requant_pool_if.sv
// Streaming bus of requant_pool: partial sums in, addressed pixels out.
interface requant_pool_if;
    import npu_pkg::*;

    logic                        in_valid;
    logic signed [ACC_WIDTH-1:0] in_data;
    logic                        in_ready;
    logic                        out_valid;
    logic [DATA_WIDTH-1:0]       out_pixel;
    logic [ADDR_WIDTH-1:0]       out_addr;
    logic                        out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_pixel, out_addr
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_pixel, out_addr
    );

endinterface

// File: rtl/requant_unit.sv
// Combinational requantiser: bias add, round-half-up right shift, clamp to
// the 8-bit range selected by relu_i. Reusable by other layers.
module requant_unit
    import npu_pkg::*;
(
    input  logic signed [ACC_WIDTH-1:0]  acc_i,
    input  logic signed [ACC_WIDTH-1:0]  bias_i,
    input  logic [4:0]                   shift_i,
    input  logic                         relu_i,
    output logic signed [Q_WIDTH-1:0]    q_o,
    output logic [DATA_WIDTH-1:0]        pix_o
);

    // Two guard bits: one for the bias add, one for the rounding add.
    localparam int RW = ACC_WIDTH + 2;
    localparam logic signed [RW-1:0] P255 = 255;
    localparam logic signed [RW-1:0] P127 = 127;
    localparam logic signed [RW-1:0] N128 = -128;
    localparam logic signed [RW-1:0] ZERO = 0;

    logic signed [RW-1:0] sum;
    logic signed [RW-1:0] rnd;
    logic signed [RW-1:0] shd;

    // Bias, rounding offset, arithmetic shift, then clamp.
    always_comb begin
        sum = {{2{acc_i[ACC_WIDTH-1]}}, acc_i} + {{2{bias_i[ACC_WIDTH-1]}}, bias_i};
        rnd = sum;
        if (shift_i != 5'd0) begin
            rnd = sum + (RW'(1) << (shift_i - 5'd1));
        end
        shd = rnd >>> shift_i;
        q_o = shd[Q_WIDTH-1:0];
        if (relu_i) begin
            if (shd < ZERO)      q_o = 9'sd0;
            else if (shd > P255) q_o = 9'sd255;
        end else begin
            if (shd < N128)      q_o = -9'sd128;
            else if (shd > P127) q_o = 9'sd127;
        end
        pix_o = to_pix(q_o, relu_i);
    end

endmodule

// File: rtl/requant_pool.sv
// Requantise one output channel of partial sums and optionally 2x2 max-pool
// them, emitting addressed 8-bit pixels. Two register stages: S1 holds the
// requantised value with its position, S2 is the output register.
module requant_pool
    import npu_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [4:0]                  in_w,
    input  logic [4:0]                  in_h,
    input  logic signed [ACC_WIDTH-1:0] bias,
    input  logic [4:0]                  shift,
    input  logic                        en_relu,
    input  logic                        pool_en,
    requant_pool_if.slave               bus,
    output logic                        busy,
    output logic                        done
);

    localparam int RB_DEPTH = MAX_W / 2;

    state_t state_q, state_d;

    logic [4:0]                  cfg_w_q, cfg_h_q, cfg_shift_q;
    logic signed [ACC_WIDTH-1:0] cfg_bias_q;
    logic                        cfg_relu_q, cfg_pool_q;
    logic [4:0]                  row_q, col_q;

    logic                        s1_valid_q;
    logic signed [Q_WIDTH-1:0]   s1_q;
    logic [DATA_WIDTH-1:0]       s1_pix_q;
    logic [4:0]                  s1_row_q, s1_col_q;

    logic signed [Q_WIDTH-1:0]   hold_q, hold_d;
    logic signed [Q_WIDTH-1:0]   rowbuf_q [RB_DEPTH];
    logic                        rb_we;
    logic signed [Q_WIDTH-1:0]   rb_wdata;

    logic                        out_valid_q;
    logic [DATA_WIDTH-1:0]       out_pixel_q, pix_d;
    logic [ADDR_WIDTH-1:0]       out_addr_q, addr_d;
    logic                        emit;

    logic signed [Q_WIDTH-1:0]   rq_q;
    logic [DATA_WIDTH-1:0]       rq_pix;
    logic signed [Q_WIDTH-1:0]   pool_max;
    logic                        stall, in_ready, accept, last_in, discard;

    assign stall    = out_valid_q && !bus.out_ready;
    assign in_ready = (state_q == RUN) && !stall;
    assign accept   = bus.in_valid && in_ready;
    assign last_in  = (row_q == cfg_h_q - 5'd1) && (col_q == cfg_w_q - 5'd1);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pixel = out_pixel_q;
    assign bus.out_addr  = out_addr_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);

    requant_unit u_requant (
        .acc_i   (bus.in_data),
        .bias_i  (cfg_bias_q),
        .shift_i (cfg_shift_q),
        .relu_i  (cfg_relu_q),
        .q_o     (rq_q),
        .pix_o   (rq_pix)
    );

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: drain waits until S1 is empty and the output register is
    // empty or handing off this cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (accept && last_in) state_d = DRAIN;
            DRAIN:   if (!s1_valid_q && (!out_valid_q || bus.out_ready)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Configuration capture on start and raster position of the next input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_w_q     <= '0;
            cfg_h_q     <= '0;
            cfg_shift_q <= '0;
            cfg_bias_q  <= '0;
            cfg_relu_q  <= 1'b0;
            cfg_pool_q  <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
        end else if (state_q == IDLE && start) begin
            cfg_w_q     <= in_w;
            cfg_h_q     <= in_h;
            cfg_shift_q <= shift;
            cfg_bias_q  <= bias;
            cfg_relu_q  <= en_relu;
            cfg_pool_q  <= pool_en;
            row_q       <= '0;
            col_q       <= '0;
        end else if (accept) begin
            if (col_q == cfg_w_q - 5'd1) begin
                col_q <= '0;
                row_q <= row_q + 5'd1;
            end else begin
                col_q <= col_q + 5'd1;
            end
        end
    end

    // S1: requantised value and its position; frozen while the output stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s1_pix_q   <= '0;
            s1_row_q   <= '0;
            s1_col_q   <= '0;
        end else if (!stall) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_q     <= rq_q;
                s1_pix_q <= rq_pix;
                s1_row_q <= row_q;
                s1_col_q <= col_q;
            end
        end
    end

    // Pooling decision for the S1 entry: track the horizontal pair in hold,
    // park even-row pair maxima in rowbuf, emit on odd row / odd column.
    always_comb begin
        emit     = 1'b0;
        pix_d    = out_pixel_q;
        addr_d   = out_addr_q;
        hold_d   = hold_q;
        rb_we    = 1'b0;
        rb_wdata = max9(hold_q, s1_q);
        pool_max = max9(max9(rowbuf_q[s1_col_q[3:1]], hold_q), s1_q);
        discard  = (cfg_w_q[0] && (s1_col_q == cfg_w_q - 5'd1)) ||
                   (cfg_h_q[0] && (s1_row_q == cfg_h_q - 5'd1));
        if (s1_valid_q && !stall) begin
            if (!cfg_pool_q) begin
                emit   = 1'b1;
                pix_d  = s1_pix_q;
                addr_d = 8'(s1_row_q) * 8'(cfg_w_q) + 8'(s1_col_q);
            end else if (!discard) begin
                unique case ({s1_row_q[0], s1_col_q[0]})
                    2'b00, 2'b10: hold_d = s1_q;
                    2'b01:        rb_we  = 1'b1;
                    default: begin
                        emit   = 1'b1;
                        pix_d  = to_pix(pool_max, cfg_relu_q);
                        addr_d = 8'(s1_row_q[4:1]) * 8'(cfg_w_q[4:1]) + 8'(s1_col_q[4:1]);
                    end
                endcase
            end
        end
    end

    // S2 output register and horizontal hold; output stays put during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
            out_addr_q  <= '0;
            hold_q      <= '0;
        end else if (!stall) begin
            out_valid_q <= emit;
            out_pixel_q <= pix_d;
            out_addr_q  <= addr_d;
            hold_q      <= hold_d;
        end
    end

    // Half-row buffer of vertical-pair candidates; contents are always
    // written before being read within a frame, so it is never cleared.
    always_ff @(posedge clk) begin
        if (rb_we) rowbuf_q[s1_col_q[3:1]] <= rb_wdata;
    end

endmodule

// File: tb/tb_requant_pool.sv
// Randomised self-checking bench for requant_pool against a plain-arithmetic
// reference model of requantisation and 2x2 max pooling.
module tb_requant_pool;
    import npu_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        start;
    logic [4:0]                  in_w, in_h, shift;
    logic signed [ACC_WIDTH-1:0] bias;
    logic                        en_relu, pool_en;
    logic                        busy, done;

    requant_pool_if bus ();

    requant_pool dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .in_w    (in_w),
        .in_h    (in_h),
        .bias    (bias),
        .shift   (shift),
        .en_relu (en_relu),
        .pool_en (pool_en),
        .bus     (bus),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    longint in_q[$];
    int     exp_pix[$];
    int     exp_addr[$];

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint ref_q(longint v, longint b, int sh, bit relu);
        longint t;
        t = v + b;
        if (sh > 0) t = t + (longint'(1) << (sh - 1));
        t = t >>> sh;
        if (relu) begin
            if (t < 0) t = 0;
            else if (t > 255) t = 255;
        end else begin
            if (t < -128) t = -128;
            else if (t > 127) t = 127;
        end
        return t;
    endfunction

    task automatic build_expected(int w, int h, longint b, int sh, bit relu, bit pool);
        longint q [16][15];
        longint m;
        exp_pix.delete();
        exp_addr.delete();
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                q[r][c] = ref_q(in_q[r*w + c], b, sh, relu);
        if (!pool) begin
            for (int r = 0; r < h; r++)
                for (int c = 0; c < w; c++) begin
                    exp_pix.push_back(int'(q[r][c] & 255));
                    exp_addr.push_back(r*w + c);
                end
        end else begin
            for (int pr = 0; pr < h/2; pr++)
                for (int pc = 0; pc < w/2; pc++) begin
                    m = q[2*pr][2*pc];
                    for (int dr = 0; dr < 2; dr++)
                        for (int dc = 0; dc < 2; dc++)
                            if (q[2*pr+dr][2*pc+dc] > m) m = q[2*pr+dr][2*pc+dc];
                    exp_pix.push_back(int'(m & 255));
                    exp_addr.push_back(pr*(w/2) + pc);
                end
        end
    endtask

    task automatic fill_rand(int n, int lo, int hi);
        in_q.delete();
        for (int i = 0; i < n; i++) in_q.push_back(longint'(lo) + longint'($urandom_range(hi - lo)));
    endtask

    // vmode: 0 always valid, 1 random. rmode: 0 always ready, 1 random,
    // 2 ready low for cycles 10..14. abort_at > 0 stops the frame early.
    task automatic run_frame(int w, int h, longint b, int sh, bit relu, bit pool,
                             int vmode, int rmode, int abort_at);
        int  n, idx, got, cyc, last_hs, last_acc, t_exp;
        bit  seen_done, lat_chk;
        int  acc_cyc[$];
        n = w * h;
        idx = 0; got = 0; cyc = 0; last_hs = -1; last_acc = -1; seen_done = 0;
        lat_chk = (vmode == 0) && (rmode == 0) && !pool;
        build_expected(w, h, b, sh, relu, pool);
        $display("[TB] frame w=%0d h=%0d bias=%0d shift=%0d relu=%0d pool=%0d outputs=%0d",
                 w, h, b, sh, relu, pool, exp_pix.size());
        @(posedge clk); #1;
        in_w = 5'(w); in_h = 5'(h); bias = 24'(b); shift = 5'(sh);
        en_relu = relu; pool_en = pool; start = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 24'(in_q[0]); bus.out_ready = 1'b1;
        @(negedge clk);
        check_val("idle_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        start = 1'b0; bus.in_valid = 1'b0;
        check_val("busy_run", busy, 1);
        while (cyc < 3000) begin
            if (abort_at > 0 && cyc == abort_at) break;
            start = (cyc == 3);
            in_w  = (cyc == 3) ? 5'd2 : 5'(w);
            bus.in_valid = (idx < n) && (vmode == 0 || $urandom_range(3) != 0);
            bus.in_data  = (idx < n) ? 24'(in_q[idx]) : '0;
            bus.out_ready = (rmode == 0) ? 1'b1 :
                            (rmode == 1) ? ($urandom_range(2) != 0) :
                            !(cyc >= 10 && cyc < 15);
            @(negedge clk);
            if (bus.out_valid && !bus.out_ready)
                check_val("stall_in_ready", bus.in_ready, 0);
            if (bus.in_valid && bus.in_ready) begin
                acc_cyc.push_back(cyc);
                last_acc = cyc;
                idx++;
            end
            if (bus.out_valid && bus.out_ready) begin
                $display("[TB] out addr=%0d pix=%0d", bus.out_addr, bus.out_pixel);
                if (got < exp_pix.size()) begin
                    check_val("out_pix", bus.out_pixel, exp_pix[got]);
                    check_val("out_addr", bus.out_addr, exp_addr[got]);
                    if (lat_chk) check_val("latency", cyc, acc_cyc[got] + 2);
                end else begin
                    check_val("extra_out", got, exp_pix.size() - 1);
                end
                got++;
                last_hs = cyc;
            end
            if (done) begin
                seen_done = 1;
                t_exp = (last_hs + 1 > last_acc + 3) ? last_hs + 1 : last_acc + 3;
                check_val("done_count", got, exp_pix.size());
                check_val("done_inputs", idx, n);
                check_val("done_time", cyc, t_exp);
            end
            // A stalled output must be identical in the following cycle.
            if (bus.out_valid && !bus.out_ready) begin
                automatic logic [7:0] p = bus.out_pixel;
                automatic logic [7:0] a = bus.out_addr;
                @(posedge clk); #1; cyc++;
                if (seen_done) break;
                check_val("hold_valid", bus.out_valid, 1);
                check_val("hold_pix", bus.out_pixel, p);
                check_val("hold_addr", bus.out_addr, a);
            end else begin
                @(posedge clk); #1; cyc++;
                if (seen_done) break;
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        start = 1'b0;
        in_w = 5'(w);
        if (abort_at == 0) begin
            if (!seen_done) check_val("done_timeout", 0, 1);
            else begin
                check_val("busy_after", busy, 0);
                check_val("done_pulse", done, 0);
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_in_ready"}, bus.in_ready, 0);
        check_val({tag, "_out_valid"}, bus.out_valid, 0);
        check_val({tag, "_out_pixel"}, bus.out_pixel, 0);
        check_val({tag, "_out_addr"}, bus.out_addr, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
    endtask

    initial begin
        int w, h;
        rst_n = 1'b0; start = 1'b0; in_w = '0; in_h = '0; bias = '0; shift = '0;
        en_relu = 1'b0; pool_en = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // Pass-through ReLU clamp.
        in_q = '{-5, 7, 300, 0, -1, 128};
        run_frame(3, 2, 0, 0, 1'b1, 1'b0, 0, 0, 0);

        // Rounding shift with bias, signed output.
        in_q = '{5, -7, 1000, -9, 3, -1000};
        run_frame(3, 2, 1, 2, 1'b0, 1'b0, 0, 0, 0);

        // Pool 4x4 over index values.
        in_q.delete();
        for (int i = 0; i < 16; i++) in_q.push_back(i);
        run_frame(4, 4, 0, 0, 1'b1, 1'b1, 0, 0, 0);

        // Pool 13x14: column 12 is huge and must never surface.
        fill_rand(182, -100, 100);
        for (int r = 0; r < 14; r++) in_q[r*13 + 12] = 1000000;
        run_frame(13, 14, 0, 0, 1'b0, 1'b1, 1, 1, 0);

        // Backpressure window in pass-through.
        fill_rand(20, -3000, 3000);
        run_frame(5, 4, 17, 4, 1'b0, 1'b0, 0, 2, 0);

        // Backpressure window in pool mode, odd height.
        fill_rand(35, -3000, 3000);
        run_frame(7, 5, -40, 3, 1'b1, 1'b1, 0, 2, 0);

        // Reset mid-frame, then a fresh full frame.
        fill_rand(64, -50000, 50000);
        run_frame(8, 8, 0, 6, 1'b0, 1'b0, 0, 0, 20);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        fill_rand(64, -50000, 50000);
        run_frame(8, 8, 100, 6, 1'b0, 1'b1, 1, 1, 0);

        // Randomised frames.
        for (int k = 0; k < 8; k++) begin
            w = 2 + int'($urandom_range(13));
            h = 2 + int'($urandom_range(14));
            fill_rand(w*h, -100000, 100000);
            run_frame(w, h, longint'($urandom_range(10000)) - 5000, int'($urandom_range(12)),
                      1'($urandom_range(1)), 1'($urandom_range(1)), 1, 1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
